// File: rtl/mem_responder.sv
// Fixed-latency single-port word memory that answers cache requests
// (IDLE -> BUSY -> RESP) and keeps saturating read/write completion counts.
module mem_responder #(
  parameter int A_WIDTH = 32,
  parameter int M_INDEX = 10,
  parameter int RD_LAT  = 3,   // 1..15
  parameter int WR_LAT  = 2    // 1..15
) (
  input  logic               clk,
  input  logic               clrn,
  input  logic [A_WIDTH-1:0] m_a,
  input  logic [31:0]        m_din,
  input  logic               m_strobe,
  input  logic               m_rw,
  output logic [31:0]        m_dout,
  output logic               m_ready,
  output logic [15:0]        rd_cnt,
  output logic [15:0]        wr_cnt
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  typedef struct packed {
    logic               rw;
    logic [M_INDEX-1:0] idx;
    logic [31:0]        din;
  } req_t;

  localparam logic [3:0] RD_LM1 = 4'(RD_LAT - 1);
  localparam logic [3:0] WR_LM1 = 4'(WR_LAT - 1);

  state_e             state_q;
  logic [3:0]         cnt_q;
  req_t               req_q;
  logic [31:0]        dout_q;
  logic               ready_q;
  logic [15:0]        rd_cnt_q, wr_cnt_q;
  logic [15:0]        rd_cnt_d, wr_cnt_d;
  logic [31:0]        mem_q [2**M_INDEX];

  logic [M_INDEX-1:0] in_idx;
  logic [3:0]         lat_m1;

  // Byte-lane bits and anything above the word index are don't-care (aliasing).
  assign in_idx = m_a[M_INDEX+1:2];
  logic unused_addr;
  if (A_WIDTH > M_INDEX + 2) begin : g_hi
    assign unused_addr = ^{m_a[A_WIDTH-1:M_INDEX+2], m_a[1:0]};
  end else begin : g_nohi
    assign unused_addr = ^m_a[1:0];
  end

  assign lat_m1   = m_rw ? WR_LM1 : RD_LM1;
  assign rd_cnt_d = (rd_cnt_q == 16'hFFFF) ? rd_cnt_q : rd_cnt_q + 16'd1;
  assign wr_cnt_d = (wr_cnt_q == 16'hFFFF) ? wr_cnt_q : wr_cnt_q + 16'd1;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      req_q    <= '0;
      dout_q   <= '0;
      ready_q  <= 1'b0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          ready_q <= 1'b0;
          if (m_strobe) begin
            req_q <= '{rw: m_rw, idx: in_idx, din: m_din};
            cnt_q <= lat_m1;
            if (lat_m1 == 4'd0) begin
              // Single-cycle latency: the request is not captured yet, so read via the live index.
              state_q <= RESP;
              ready_q <= 1'b1;
              if (!m_rw) dout_q <= mem_q[in_idx];
            end else begin
              state_q <= BUSY;
            end
          end
        end
        BUSY: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= RESP;
            ready_q <= 1'b1;
            if (!req_q.rw) dout_q <= mem_q[req_q.idx];
          end
        end
        RESP: begin
          ready_q <= 1'b0;
          state_q <= IDLE;
          if (req_q.rw) wr_cnt_q <= wr_cnt_d;
          else          rd_cnt_q <= rd_cnt_d;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Array has no reset; an async reset forces IDLE, which cancels a pending write.
  always_ff @(posedge clk) begin
    if (state_q == RESP && req_q.rw) mem_q[req_q.idx] <= req_q.din;
  end

  assign m_dout  = dout_q;
  assign m_ready = ready_q;
  assign rd_cnt  = rd_cnt_q;
  assign wr_cnt  = wr_cnt_q;

endmodule

// File: tb/tb_mem_responder.sv
// Randomised bench for mem_responder against a word-level memory/latency model;
// a second RD_LAT=WR_LAT=1 instance covers minimum latency and counter saturation.
module tb_mem_responder;

  localparam int RDL = 3;
  localparam int WRL = 2;

  logic clk = 1'b0, clk2 = 1'b0, clrn = 1'b0;
  always #5 clk  = ~clk;
  always #1 clk2 = ~clk2;

  logic [31:0] a = '0, din = '0, dout;
  logic        strobe = 1'b0, rw = 1'b0, ready;
  logic [15:0] rdc, wrc;

  logic [31:0] a2 = '0, din2 = '0, dout2;
  logic        strobe2 = 1'b0, rw2 = 1'b0, ready2;
  logic [15:0] rdc2, wrc2;

  mem_responder #(.A_WIDTH(32), .M_INDEX(10), .RD_LAT(RDL), .WR_LAT(WRL)) u_dut (
    .clk(clk), .clrn(clrn), .m_a(a), .m_din(din), .m_strobe(strobe), .m_rw(rw),
    .m_dout(dout), .m_ready(ready), .rd_cnt(rdc), .wr_cnt(wrc));

  mem_responder #(.A_WIDTH(32), .M_INDEX(10), .RD_LAT(1), .WR_LAT(1)) u_fast (
    .clk(clk2), .clrn(clrn), .m_a(a2), .m_din(din2), .m_strobe(strobe2), .m_rw(rw2),
    .m_dout(dout2), .m_ready(ready2), .rd_cnt(rdc2), .wr_cnt(wrc2));

  int n_chk = 0, n_pass = 0;

  // Reference model: word-indexed contents, last read word, saturating counts.
  logic [31:0] mem_m [int];
  logic [31:0] dout_m = '0;
  int rd_m = 0, wr_m = 0;

  function automatic int widx(input logic [31:0] addr);
    return int'(addr[11:2]);
  endfunction

  function automatic int sat(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic model_txn(input logic rw_i, input logic [31:0] addr, input logic [31:0] wd);
    if (rw_i) begin mem_m[widx(addr)] = wd; wr_m = sat(wr_m + 1); end
    else begin dout_m = mem_m[widx(addr)]; rd_m = sat(rd_m + 1); end
  endtask

  // Issues one request, returns cycles-to-ready, m_dout in the ready cycle, and m_ready one cycle later.
  task automatic do_txn(input logic rw_i, input logic [31:0] addr, input logic [31:0] wd,
                        input bit perturb, output int lat, output logic [31:0] d, output logic extra);
    @(negedge clk);
    a = addr; din = wd; rw = rw_i; strobe = 1'b1;
    lat = 0; d = dout;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (ready) begin lat = k; d = dout; break; end
      if (perturb) begin
        strobe = (k == 1) ? 1'b0 : 1'($urandom_range(0, 1));
        a = $urandom; din = $urandom; rw = 1'($urandom_range(0, 1));
      end else strobe = 1'b0;
    end
    strobe = 1'b0;
    @(negedge clk);
    extra = ready;
  endtask

  task automatic test_reset;
    #2;
    n_chk++; if (ready !== 1'b0) $display("FAIL reset_ready got %0b want 0", ready); else n_pass++;
    n_chk++; if (dout !== 32'h0) $display("FAIL reset_dout got %h want 0", dout); else n_pass++;
    n_chk++; if (rdc !== 16'h0) $display("FAIL reset_rdcnt got %0d want 0", rdc); else n_pass++;
    n_chk++; if (wrc !== 16'h0) $display("FAIL reset_wrcnt got %0d want 0", wrc); else n_pass++;
    n_chk++; if (rdc2 !== 16'h0 || ready2 !== 1'b0) $display("FAIL reset_fast got rd=%0d rdy=%0b want 0/0", rdc2, ready2); else n_pass++;
    @(negedge clk); clrn = 1'b1;
  endtask

  task automatic test_defaults;
    int lat; logic [31:0] d; logic ex;
    do_txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, lat, d, ex);
    model_txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    n_chk++; if (lat != 2) $display("FAIL def_wr_lat got %0d want 2", lat); else n_pass++;
    n_chk++; if (d !== 32'h0) $display("FAIL def_wr_dout got %h want 0", d); else n_pass++;
    n_chk++; if (ex !== 1'b0) $display("FAIL def_wr_pulse got %0b want 0", ex); else n_pass++;
    n_chk++; if (wrc !== 16'd1) $display("FAIL def_wrcnt got %0d want 1", wrc); else n_pass++;
    do_txn(1'b0, 32'h0000_0010, 32'h0, 1'b0, lat, d, ex);
    model_txn(1'b0, 32'h0000_0010, 32'h0);
    n_chk++; if (lat != 3) $display("FAIL def_rd_lat got %0d want 3", lat); else n_pass++;
    n_chk++; if (d !== 32'hDEAD_BEEF) $display("FAIL def_rd_dout got %h want deadbeef", d); else n_pass++;
    n_chk++; if (ex !== 1'b0) $display("FAIL def_rd_pulse got %0b want 0", ex); else n_pass++;
    n_chk++; if (rdc !== 16'd1) $display("FAIL def_rdcnt got %0d want 1", rdc); else n_pass++;
  endtask

  task automatic test_alias;
    int lat; logic [31:0] d; logic ex;
    do_txn(1'b1, 32'h0000_0004, 32'h1234_5678, 1'b0, lat, d, ex);
    model_txn(1'b1, 32'h0000_0004, 32'h1234_5678);
    do_txn(1'b0, 32'h0000_1004, 32'h0, 1'b0, lat, d, ex);
    model_txn(1'b0, 32'h0000_1004, 32'h0);
    n_chk++; if (d !== 32'h1234_5678) $display("FAIL alias_dout got %h want 12345678", d); else n_pass++;
  endtask

  task automatic test_abort_ignored;
    int lat; logic [31:0] d; logic ex;
    do_txn(1'b0, 32'h0000_0010, 32'h0, 1'b1, lat, d, ex);
    model_txn(1'b0, 32'h0000_0010, 32'h0);
    n_chk++; if (lat != RDL) $display("FAIL abort_lat got %0d want %0d", lat, RDL); else n_pass++;
    n_chk++; if (d !== 32'hDEAD_BEEF) $display("FAIL abort_dout got %h want deadbeef", d); else n_pass++;
    n_chk++; if (ex !== 1'b0) $display("FAIL abort_pulse got %0b want 0", ex); else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [31:0] addrs [3];
    int pc [3]; logic [31:0] dv [3];
    int np, rd0;
    addrs[0] = 32'h0000_0010; addrs[1] = 32'h0000_0004; addrs[2] = 32'hFFFF_F013;
    rd0 = rd_m; np = 0;
    @(negedge clk); a = addrs[0]; rw = 1'b0; strobe = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (ready) begin
        if (np < 3) begin pc[np] = k; dv[np] = dout; end
        np++;
        if (np < 3) a = addrs[np]; else strobe = 1'b0;
      end
    end
    strobe = 1'b0;
    n_chk++; if (np != 3) $display("FAIL b2b_pulses got %0d want 3", np); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      model_txn(1'b0, addrs[i], 32'h0);
      n_chk++; if (np > i && pc[i] != 3 + 4 * i) $display("FAIL b2b_cycle%0d got %0d want %0d", i, pc[i], 3 + 4 * i); else n_pass++;
      n_chk++; if (np > i && dv[i] !== dout_m) $display("FAIL b2b_dout%0d got %h want %h", i, dv[i], dout_m); else n_pass++;
    end
    n_chk++; if (int'(rdc) != rd0 + 3) $display("FAIL b2b_rdcnt got %0d want %0d", rdc, rd0 + 3); else n_pass++;
  endtask

  task automatic test_reset_mid_write;
    int lat, seen; logic [31:0] d; logic ex;
    do_txn(1'b1, 32'h0000_0014, 32'h5555_5555, 1'b0, lat, d, ex);
    model_txn(1'b1, 32'h0000_0014, 32'h5555_5555);
    @(negedge clk); a = 32'h0000_0014; din = 32'hAAAA_AAAA; rw = 1'b1; strobe = 1'b1;
    @(negedge clk); strobe = 1'b0;
    #1 clrn = 1'b0;
    #1;
    n_chk++; if (wrc !== 16'd0) $display("FAIL rst_async_wrcnt got %0d want 0", wrc); else n_pass++;
    n_chk++; if (rdc !== 16'd0) $display("FAIL rst_async_rdcnt got %0d want 0", rdc); else n_pass++;
    n_chk++; if (dout !== 32'h0) $display("FAIL rst_async_dout got %h want 0", dout); else n_pass++;
    seen = 0;
    for (int k = 0; k < 4; k++) begin @(negedge clk); if (ready) seen++; end
    clrn = 1'b1;
    for (int k = 0; k < 4; k++) begin @(negedge clk); if (ready) seen++; end
    n_chk++; if (seen != 0) $display("FAIL rst_no_ready got %0d pulses want 0", seen); else n_pass++;
    n_chk++; if (wrc !== 16'd0) $display("FAIL rst_wrcnt got %0d want 0", wrc); else n_pass++;
    rd_m = 0; wr_m = 0; dout_m = '0;
    do_txn(1'b0, 32'h0000_0014, 32'h0, 1'b0, lat, d, ex);
    model_txn(1'b0, 32'h0000_0014, 32'h0);
    n_chk++; if (d !== 32'h5555_5555) $display("FAIL rst_keep_mem got %h want 55555555", d); else n_pass++;
    n_chk++; if (int'(rdc) != rd_m) $display("FAIL rst_rdcnt got %0d want %0d", rdc, rd_m); else n_pass++;
  endtask

  task automatic test_random;
    int pool [8];
    int lat; logic [31:0] d, addr, wd; logic ex, rwv;
    for (int i = 0; i < 8; i++) begin
      pool[i] = $urandom_range(0, 1023);
      addr = {20'($urandom), 10'(pool[i]), 2'($urandom)};
      wd = $urandom;
      do_txn(1'b1, addr, wd, 1'b0, lat, d, ex);
      model_txn(1'b1, addr, wd);
    end
    for (int t = 0; t < 40; t++) begin
      rwv = 1'($urandom_range(0, 1));
      addr = {20'($urandom), 10'(pool[$urandom_range(0, 7)]), 2'($urandom)};
      wd = $urandom;
      do_txn(rwv, addr, wd, 1'($urandom_range(0, 1)), lat, d, ex);
      model_txn(rwv, addr, wd);
      n_chk++; if (lat != (rwv ? WRL : RDL)) $display("FAIL rnd%0d_lat got %0d want %0d", t, lat, rwv ? WRL : RDL); else n_pass++;
      n_chk++; if (d !== dout_m) $display("FAIL rnd%0d_dout got %h want %h", t, d, dout_m); else n_pass++;
      n_chk++; if (ex !== 1'b0) $display("FAIL rnd%0d_pulse got %0b want 0", t, ex); else n_pass++;
      n_chk++; if (int'(rdc) != rd_m || int'(wrc) != wr_m)
        $display("FAIL rnd%0d_cnt got %0d/%0d want %0d/%0d", t, rdc, wrc, rd_m, wr_m); else n_pass++;
    end
  endtask

  task automatic test_rdlat1;
    @(negedge clk2); a2 = 32'h0000_0020; din2 = 32'hCAFE_F00D; rw2 = 1'b1; strobe2 = 1'b1;
    @(negedge clk2); strobe2 = 1'b0;
    n_chk++; if (ready2 !== 1'b1) $display("FAIL lat1_wr_ready got %0b want 1", ready2); else n_pass++;
    @(negedge clk2);
    n_chk++; if (ready2 !== 1'b0 || wrc2 !== 16'd1) $display("FAIL lat1_wr_after got rdy=%0b wr=%0d want 0/1", ready2, wrc2); else n_pass++;
    @(negedge clk2); a2 = 32'h0000_0020; rw2 = 1'b0; strobe2 = 1'b1;
    @(negedge clk2); strobe2 = 1'b0;
    n_chk++; if (ready2 !== 1'b1) $display("FAIL lat1_rd_ready got %0b want 1", ready2); else n_pass++;
    n_chk++; if (dout2 !== 32'hCAFE_F00D) $display("FAIL lat1_rd_dout got %h want cafef00d", dout2); else n_pass++;
    @(negedge clk2);
    n_chk++; if (ready2 !== 1'b0 || rdc2 !== 16'd1) $display("FAIL lat1_rd_after got rdy=%0b rd=%0d want 0/1", ready2, rdc2); else n_pass++;
  endtask

  task automatic test_saturation;
    int done, last;
    done = 1; last = -1;
    @(negedge clk2); a2 = '0; rw2 = 1'b0; strobe2 = 1'b1;
    for (int k = 0; k < 140000; k++) begin
      @(negedge clk2);
      if (done >= 65534 && done != last) begin
        last = done;
        n_chk++; if (int'(rdc2) != sat(done)) $display("FAIL sat_rdcnt@%0d got %0d want %0d", done, rdc2, sat(done)); else n_pass++;
      end
      if (done == 65537) break;
      if (ready2) begin done++; if (done == 65537) strobe2 = 1'b0; end
    end
    strobe2 = 1'b0;
    n_chk++; if (done != 65537 || last != 65537) $display("FAIL sat_budget got %0d reads want 65537", done); else n_pass++;
    n_chk++; if (rdc2 !== 16'hFFFF) $display("FAIL sat_final got %h want ffff", rdc2); else n_pass++;
  endtask

  initial begin
    test_reset;
    test_defaults;
    test_alias;
    test_abort_ignored;
    test_back_to_back;
    test_reset_mid_write;
    test_random;
    test_rdlat1;
    test_saturation;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
